signed_shift_divider: RTL and testbench

Sequential signed two's-complement divider, the inverse companion to the calculator's shift-add multiply block. It accepts a dividend and divisor on a one-cycle `start`, runs a fixed-latency restoring shift-subtract loop on magnitudes, and applies a sign fix-up. It returns a quotient truncated toward zero and a remainder carrying the dividend's sign, with `done` pulsed for one cycle. It sits beside the multiply block in the calculator datapath and shares its start/done handshake.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/signed_shift_divider_negate.sv | 18 +
 rtl/signed_shift_divider.sv | 200 ++++++++++++++++++++
 tb/tb_signed_shift_divider.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: divider FSM states, default operand width
// and the most-negative two's-complement constant helper.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Bit pattern with only bit (width-1) set; callers slice the low width bits.
  function automatic logic [63:0] most_negative(input int width);
    most_negative = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/signed_shift_divider_negate.sv
// Combinational two's-complement negate with a select: passes the value
// through when i_neg is low, returns its negation when high. Negating the
// most-negative value wraps back onto itself, which the divider relies on
// when it reads the result as an unsigned magnitude.
module divide_negate #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_value,
  input  logic         i_neg,
  output logic [N-1:0] o_result
);

  // Select between pass-through and the negated value.
  always_comb begin
    o_result = i_neg ? (~i_value + N'(1)) : i_value;
  end

endmodule

// File: rtl/signed_shift_divider.sv
// Fixed-latency signed divider: latch operands, take magnitudes, run WIDTH
// restoring shift-subtract steps, then restore signs. Quotient truncates
// toward zero; remainder takes the dividend's sign. Divide-by-zero and the
// most-negative / -1 overflow are flagged but take the same latency.
module signed_shift_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int                CW          = $clog2(WIDTH) + 1;
  localparam logic [63:0]       MOST_NEG_64 = most_negative(WIDTH);
  localparam logic [WIDTH-1:0]  MOST_NEG    = MOST_NEG_64[WIDTH-1:0];
  localparam logic [CW-1:0]     LAST_ITER   = CW'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_next;

  // Operands as captured on the accepted start.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Working state of the magnitude division.
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_mag_b;
  logic [WIDTH:0]   r_part;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_count;
  logic             r_dbz;
  logic             r_ovf;

  // Result registers driving the outputs.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz_out;
  logic             r_ovf_out;

  // Negate lanes: lane 0 handles dividend / quotient, lane 1 divisor /
  // remainder. ABS and FIX never overlap, so the two lanes are shared.
  logic [WIDTH-1:0] w_neg_in  [2];
  logic             w_neg_sel [2];
  logic [WIDTH-1:0] w_neg_out [2];
  logic             w_fix;

  // One restoring step.
  logic [WIDTH+1:0] w_shift;
  logic             w_fits;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_part_next;
  logic [WIDTH-1:0] w_quo_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the state-decoded busy/done outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = ABS;
        end
      end
      ABS: begin
        w_state_next = DIV;
      end
      DIV: begin
        if (r_count == LAST_ITER) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Route operands during ABS and raw results during FIX into the negate lanes.
  always_comb begin
    w_fix        = (r_state == FIX);
    w_neg_in[0]  = w_fix ? r_quo : r_a;
    w_neg_sel[0] = w_fix ? r_sign_q : r_a[WIDTH-1];
    w_neg_in[1]  = w_fix ? r_part[WIDTH-1:0] : r_b;
    w_neg_sel[1] = w_fix ? r_sign_r : r_b[WIDTH-1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_neg
      divide_negate #(
        .N(WIDTH)
      ) u_negate (
        .i_value (w_neg_in[gi]),
        .i_neg   (w_neg_sel[gi]),
        .o_result(w_neg_out[gi])
      );
    end
  endgenerate

  // Shift {P,Q} left, trial-subtract |b|, keep the difference when it fits.
  always_comb begin
    w_shift     = {r_part, r_quo[WIDTH-1]};
    w_fits      = ({1'b0, w_shift} >= {3'b000, r_mag_b});
    w_sub       = w_shift[WIDTH:0] - {1'b0, r_mag_b};
    w_part_next = w_fits ? w_sub : w_shift[WIDTH:0];
    w_quo_next  = {r_quo[WIDTH-2:0], w_fits};
  end

  // Datapath: capture, magnitude setup, iteration and sign fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_mag_b   <= '0;
      r_part    <= '0;
      r_quo     <= '0;
      r_count   <= '0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_dbz_out <= 1'b0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= b;
          end
        end
        ABS: begin
          r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sign_r <= r_a[WIDTH-1];
          r_quo    <= w_neg_out[0];
          r_mag_b  <= w_neg_out[1];
          r_part   <= '0;
          r_count  <= '0;
          r_dbz    <= (r_b == '0);
          r_ovf    <= (r_a == MOST_NEG) && (r_b == '1);
        end
        DIV: begin
          r_part  <= w_part_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + CW'(1);
        end
        FIX: begin
          // A zero divisor leaves the loop output meaningless; report q=0, r=a.
          if (r_dbz) begin
            r_q <= '0;
            r_r <= r_a;
          end else begin
            r_q <= w_neg_out[0];
            r_r <= w_neg_out[1];
          end
          r_dbz_out <= r_dbz;
          r_ovf_out <= r_ovf;
        end
        default: begin
        end
      endcase
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz_out;
  assign overflow    = r_ovf_out;

endmodule

// File: tb/tb_signed_shift_divider.sv
// Self-checking bench for signed_shift_divider (WIDTH=4): directed vectors,
// ignored-start, reset abort and a shuffled sweep over all operand pairs
// against an integer-arithmetic reference.
module tb_signed_shift_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  signed_shift_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .q          (q),
    .r          (r),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // Reference: truncating signed division with the two special cases.
  function automatic void ref_div(input logic [3:0] da, input logic [3:0] db,
                                  output logic [3:0] eq, output logic [3:0] er,
                                  output logic edz, output logic eov);
    int sa;
    int sb;
    sa  = int'($signed(da));
    sb  = int'($signed(db));
    edz = 1'b0;
    eov = 1'b0;
    if (sb == 0) begin
      eq  = 4'b0000;
      er  = da;
      edz = 1'b1;
    end else if (sa == -8 && sb == -1) begin
      eq  = 4'b1000;
      er  = 4'b0000;
      eov = 1'b1;
    end else begin
      eq = 4'(sa / sb);
      er = 4'(sa % sb);
    end
  endfunction

  // Issue one start and observe ten cycles afterwards; optionally pulse a
  // second start (random operands) after sample number restart_at.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_in, input int restart_at,
                       output logic [3:0] oq, output logic [3:0] orr,
                       output logic odz, output logic oov,
                       output int done_at, output int done_cnt, output int busy_cnt,
                       output logic busy0, output logic hold_ok);
    oq = 'x; orr = 'x; odz = 1'bx; oov = 1'bx;
    done_at = -1; done_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    a = ta; b = tb_in; start = 1'b1;
    @(negedge clk);
    busy0 = busy;
    start = 1'b0; a = 4'($urandom); b = 4'($urandom);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n; oq = q; orr = r; odz = div_by_zero; oov = overflow;
        end
      end
      if (busy) busy_cnt++;
      if (n == restart_at) begin
        start = 1'b1; a = 4'($urandom); b = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    hold_ok = (q === oq) && (r === orr) && (div_by_zero === odz) && (overflow === oov);
    $display("[TB] a=%b b=%b -> q=%b r=%b dz=%b ov=%b done_at=%0d done_cnt=%0d",
             ta, tb_in, oq, orr, odz, oov, done_at, done_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({q, r, busy, done, div_by_zero, overflow} !== 12'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got q=%b r=%b busy=%b done=%b dz=%b ov=%b want all zero",
               q, r, busy, done, div_by_zero, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] va [7] = '{4'b0111, 4'b1001, 4'b0111, 4'b1010, 4'b1000, 4'b0100, 4'b0101};
    logic [3:0] vb [7] = '{4'b0010, 4'b0010, 4'b1110, 4'b1101, 4'b1111, 4'b0001, 4'b0000};
    logic [3:0] vq [7] = '{4'b0011, 4'b1101, 4'b1101, 4'b0010, 4'b1000, 4'b0100, 4'b0000};
    logic [3:0] vr [7] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0101};
    logic       vz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       vo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] oq, orr;
    logic       odz, oov, busy0, hold_ok;
    int         done_at, done_cnt, busy_cnt;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], 0, oq, orr, odz, oov, done_at, done_cnt, busy_cnt, busy0, hold_ok);
      tests_run++;
      if ({oq, orr, odz, oov} !== {vq[i], vr[i], vz[i], vo[i]}) begin
        tests_failed++;
        $display("FAIL directed_result a=%b b=%b got q=%b r=%b dz=%b ov=%b want q=%b r=%b dz=%b ov=%b",
                 va[i], vb[i], oq, orr, odz, oov, vq[i], vr[i], vz[i], vo[i]);
      end
      tests_run++;
      if (done_at !== 6 || done_cnt !== 1 || busy_cnt !== 6 || busy0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed_timing a=%b b=%b got done_at=%0d done_cnt=%0d busy_cnt=%0d busy0=%b want 6 1 6 1",
                 va[i], vb[i], done_at, done_cnt, busy_cnt, busy0);
      end
      tests_run++;
      if (hold_ok !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed_hold a=%b b=%b got q=%b r=%b after done want q=%b r=%b",
                 va[i], vb[i], q, r, oq, orr);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [3:0] oq, orr;
    logic       odz, oov, busy0, hold_ok;
    int         done_at, done_cnt, busy_cnt;
    // Second start two cycles in: must not disturb 7/2.
    do_op(4'b0111, 4'b0010, 1, oq, orr, odz, oov, done_at, done_cnt, busy_cnt, busy0, hold_ok);
    tests_run++;
    if ({oq, orr, odz, oov} !== {4'b0011, 4'b0001, 2'b00} || done_cnt !== 1 || done_at !== 6) begin
      tests_failed++;
      $display("FAIL ignore_midrun got q=%b r=%b done_cnt=%0d done_at=%0d want q=0011 r=0001 1 6",
               oq, orr, done_cnt, done_at);
    end
    // Start during the DONE cycle: dropped, divider returns to idle.
    do_op(4'b1001, 4'b0011, 6, oq, orr, odz, oov, done_at, done_cnt, busy_cnt, busy0, hold_ok);
    tests_run++;
    if ({oq, orr} !== {4'b1110, 4'b1111} || done_cnt !== 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_in_done got q=%b r=%b done_cnt=%0d busy=%b want q=1110 r=1111 1 0",
               oq, orr, done_cnt, busy);
    end
  endtask

  task automatic test_rst_abort();
    logic [3:0] oq, orr;
    logic       odz, oov, busy0, hold_ok;
    int         done_at, done_cnt, busy_cnt;
    int         late_done;
    do_op(4'b0111, 4'b0010, 0, oq, orr, odz, oov, done_at, done_cnt, busy_cnt, busy0, hold_ok);
    @(negedge clk);
    a = 4'b0110; b = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({q, r, busy, done, div_by_zero, overflow} !== 12'b0) begin
      tests_failed++;
      $display("FAIL rst_abort_outputs got q=%b r=%b busy=%b done=%b dz=%b ov=%b want all zero",
               q, r, busy, done, div_by_zero, overflow);
    end
    rst = 1'b0;
    late_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done) late_done++;
    end
    tests_run++;
    if (late_done !== 0) begin
      tests_failed++;
      $display("FAIL rst_abort_no_done got %0d done pulses want 0", late_done);
    end
    do_op(4'b0110, 4'b0001, 0, oq, orr, odz, oov, done_at, done_cnt, busy_cnt, busy0, hold_ok);
    tests_run++;
    if ({oq, orr, odz, oov} !== {4'b0110, 4'b0000, 2'b00} || done_at !== 6 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL rst_abort_restart got q=%b r=%b done_at=%0d done_cnt=%0d want q=0110 r=0000 6 1",
               oq, orr, done_at, done_cnt);
    end
  endtask

  task automatic test_sweep();
    int         order [256];
    logic [3:0] ta, tb_v, eq, er, oq, orr;
    logic       edz, eov, odz, oov, busy0, hold_ok;
    int         done_at, done_cnt, busy_cnt;
    int         j, tmp;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      ta   = 4'(order[i] >> 4);
      tb_v = 4'(order[i]);
      ref_div(ta, tb_v, eq, er, edz, eov);
      do_op(ta, tb_v, 0, oq, orr, odz, oov, done_at, done_cnt, busy_cnt, busy0, hold_ok);
      tests_run++;
      if ({oq, orr, odz, oov} !== {eq, er, edz, eov}) begin
        tests_failed++;
        $display("FAIL sweep_result a=%b b=%b got q=%b r=%b dz=%b ov=%b want q=%b r=%b dz=%b ov=%b",
                 ta, tb_v, oq, orr, odz, oov, eq, er, edz, eov);
      end
      tests_run++;
      if (done_at !== 6 || done_cnt !== 1) begin
        tests_failed++;
        $display("FAIL sweep_latency a=%b b=%b got done_at=%0d done_cnt=%0d want 6 1",
                 ta, tb_v, done_at, done_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_rst_abort();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
